// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - shared op/state types and nibble constants for the serial add/sub ALU
package alu_serial_pkg;

    localparam int NIBBLE_BITS = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_CP  = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Codes 5..7 are reserved and never start an operation.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= OP_CP;
    endfunction

    // SUB, SBC and CP run the adder on ~b with an inverted carry-in.
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    function automatic logic op_uses_cin(input logic [2:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_nibble_add.sv
// rtl/alu_nibble_add.sv - combinational 4-bit adder slice with carry in/out
//   a, b : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of the top bit
module alu_nibble_add
    import alu_serial_pkg::*;
(
    input  logic [NIBBLE_BITS-1:0] a,
    input  logic [NIBBLE_BITS-1:0] b,
    input  logic                   ci,
    output logic [NIBBLE_BITS-1:0] s,
    output logic                   co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_BITS{1'b0}}, ci};

endmodule

// File: rtl/alu_serial_addsub.sv
// rtl/alu_serial_addsub.sv - nibble-serial add/subtract/compare ALU with Z/N/H/C flags
//   clk, nreset          : clock, asynchronous active-low reset
//   start, op, a, b, cin : request and operands, sampled when accepted (IDLE or DONE)
//   busy                 : operation in progress
//   done                 : one-cycle pulse, result and flags valid
//   result, flag_z/n/h/c : held from the DONE entry until the next one
module alu_serial_addsub
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_h,
    output logic             flag_c
);

    localparam int NIBBLES = WIDTH / NIBBLE_BITS;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_BITS) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("alu_serial_addsub: WIDTH must be a multiple of 4 in 4..32");
    end

    alu_state_e       state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_full;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             h_q;
    logic             accept, last_nib, is_sub_q;
    logic [NIBBLE_BITS-1:0] nib_a, nib_b, nib_s;
    logic             nib_co, nib_cb;

    assign accept   = start && op_is_valid(op) && (state_q != ST_RUN);
    assign last_nib = (idx_q == LAST_IDX);
    assign is_sub_q = op_is_sub(op_q);

    assign nib_a = a_q[int'(idx_q)*NIBBLE_BITS +: NIBBLE_BITS];
    assign nib_b = b_q[int'(idx_q)*NIBBLE_BITS +: NIBBLE_BITS] ^ {NIBBLE_BITS{is_sub_q}};

    alu_nibble_add u_nibble_add (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // Flags report borrow for subtract ops, i.e. the inverted adder carry.
    assign nib_cb = nib_co ^ is_sub_q;

    // Partial sum with the current nibble merged in; on the last nibble this is the full result.
    always_comb begin
        sum_full = sum_q;
        sum_full[int'(idx_q)*NIBBLE_BITS +: NIBBLE_BITS] = nib_s;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_nib) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            h_q     <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            idx_q   <= '0;
            // Adder carry-in is ~ci for subtract ops so a + ~b + ~ci == a - b - ci.
            carry_q <= (op_uses_cin(op) & cin) ^ op_is_sub(op);
        end else if (state_q == ST_RUN) begin
            carry_q <= nib_co;
            sum_q   <= sum_full;
            idx_q   <= last_nib ? '0 : idx_q + IDX_W'(1);
            if (idx_q == '0) h_q <= nib_cb;
            if (last_nib) begin
                result <= (op_q == OP_CP) ? a_q : sum_full;
                flag_z <= (sum_full == '0);
                flag_n <= is_sub_q;
                // With a single nibble the half-carry comes straight from this step.
                flag_h <= (idx_q == '0) ? nib_cb : h_q;
                flag_c <= nib_cb;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// tb/tb_alu_serial_addsub.sv - directed and randomized check of alu_serial_addsub (WIDTH 8 and 16)
module tb_alu_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        h;
        logic        c;
    } ref_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        st_start [2];
    logic [2:0]  st_op    [2];
    logic [15:0] st_a     [2];
    logic [15:0] st_b     [2];
    logic        st_cin   [2];

    logic        busy8, done8, z8, n8, h8, c8;
    logic [7:0]  r8;
    logic        busy16, done16, z16, n16, h16, c16;
    logic [15:0] r16;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, lat2, seen;

    always #5 clk = ~clk;

    alu_serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .nreset(nreset), .start(st_start[0]), .op(st_op[0]),
        .a(st_a[0][7:0]), .b(st_b[0][7:0]), .cin(st_cin[0]),
        .busy(busy8), .done(done8), .result(r8),
        .flag_z(z8), .flag_n(n8), .flag_h(h8), .flag_c(c8)
    );

    alu_serial_addsub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .nreset(nreset), .start(st_start[1]), .op(st_op[1]),
        .a(st_a[1]), .b(st_b[1]), .cin(st_cin[1]),
        .busy(busy16), .done(done16), .result(r16),
        .flag_z(z16), .flag_n(n16), .flag_h(h16), .flag_c(c16)
    );

    // Reference arithmetic on wide integers: full-width sum/difference plus the low-nibble sum.
    function automatic ref_t ref_calc(input int w, input logic [2:0] op,
                                      input logic [15:0] a, input logic [15:0] b, input logic cin);
        ref_t   r;
        longint mask, aa, bb, ci, full, diff;
        mask = (longint'(1) << w) - 1;
        aa   = longint'(a) & mask;
        bb   = longint'(b) & mask;
        ci   = ((op == 3'd1 || op == 3'd3) && cin) ? 1 : 0;
        r    = '0;
        if (op <= 3'd1) begin
            full  = aa + bb + ci;
            r.res = 16'(full & mask);
            r.z   = (full & mask) == 0;
            r.c   = (full >> w) != 0;
            r.h   = ((aa & 15) + (bb & 15) + ci) > 15;
        end else begin
            diff  = aa - bb - ci;
            r.res = (op == 3'd4) ? 16'(aa) : 16'(diff & mask);
            r.z   = (diff & mask) == 0;
            r.n   = 1'b1;
            r.c   = diff < 0;
            r.h   = ((aa & 15) - (bb & 15) - ci) < 0;
        end
        return r;
    endfunction

    // Transaction-level model: an accepted request completes NIBBLES cycles later.
    for (genvar g = 0; g < 2; g++) begin : g_model
        localparam int MW = (g == 0) ? 8 : 16;
        logic m_run, m_done;
        int   m_rem;
        ref_t m_out, m_pend;
        always @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                m_run  <= 1'b0;
                m_done <= 1'b0;
                m_rem  <= 0;
                m_out  <= '0;
                m_pend <= '0;
            end else if (m_run) begin
                m_rem  <= m_rem - 1;
                m_done <= (m_rem == 1);
                if (m_rem == 1) begin
                    m_run <= 1'b0;
                    m_out <= m_pend;
                end
            end else begin
                m_done <= 1'b0;
                if (st_start[g] && st_op[g] <= 3'd4) begin
                    m_run  <= 1'b1;
                    m_rem  <= MW / 4;
                    m_pend <= ref_calc(MW, st_op[g], st_a[g], st_b[g], st_cin[g]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("cycle_w8", {10'b0, busy8, done8, 8'h00, r8, z8, n8, h8, c8},
            {10'b0, g_model[0].m_run, g_model[0].m_done, g_model[0].m_out});
        chk("cycle_w16", {10'b0, busy16, done16, r16, z16, n16, h16, c16},
            {10'b0, g_model[1].m_run, g_model[1].m_done, g_model[1].m_out});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic go(input int i, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic cin);
        st_start[i] = 1'b1;
        st_op[i]    = op;
        st_a[i]     = a;
        st_b[i]     = b;
        st_cin[i]   = cin;
        tick();
        st_start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int l);
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if ((i == 0) ? done8 : done16) begin
                l = k;
                break;
            end
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        nreset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_start[i] = 1'b0;
            st_op[i]    = 3'd0;
            st_a[i]     = '0;
            st_b[i]     = '0;
            st_cin[i]   = 1'b0;
        end
        tick();
        tick();
        chk("reset_w8", {busy8, done8, r8, z8, n8, h8, c8}, 32'h0);
        chk("reset_w16", {busy16, done16, r16, z16, n16, h16, c16}, 32'h0);

        chk("pin_add", ref_calc(8, 3'd0, 16'h0F, 16'h01, 1'b0), {16'h0010, 4'b0010});
        chk("pin_sbc", ref_calc(8, 3'd3, 16'h00, 16'h00, 1'b1), {16'h00FF, 4'b0111});
        chk("pin_cp16", ref_calc(16, 3'd4, 16'h1234, 16'h1235, 1'b0), {16'h1234, 4'b0111});

        nreset = 1'b1;
        go(0, 3'd0, 16'h0F, 16'h01, 1'b0);
        wait_done(0, lat);
        chk("lat_add8", lat, 2);
        chk("add8", {r8, z8, n8, h8, c8}, {8'h10, 4'b0010});

        go(0, 3'd1, 16'hFF, 16'h00, 1'b1);
        wait_done(0, lat);
        chk("adc8", {r8, z8, n8, h8, c8}, {8'h00, 4'b1011});

        go(0, 3'd2, 16'h10, 16'h01, 1'b0);
        wait_done(0, lat);
        chk("sub8", {r8, z8, n8, h8, c8}, {8'h0F, 4'b0110});
        go(0, 3'd4, 16'h42, 16'h42, 1'b0);
        chk("b2b_busy", {busy8, done8}, 2'b10);
        wait_done(0, lat);
        chk("lat_cp8", lat, 2);
        chk("cp8", {r8, z8, n8, h8, c8}, {8'h42, 4'b1100});

        go(1, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        st_start[1] = 1'b1;
        st_op[1]    = 3'd2;
        st_a[1]     = 16'h5555;
        st_b[1]     = 16'h0001;
        tick();
        st_start[1] = 1'b0;
        wait_done(1, lat2);
        chk("lat_add16", 2 + lat2, 4);
        chk("add16", {r16, z16, n16, h16, c16}, {16'h0000, 4'b1011});

        go(0, 3'd3, 16'h00, 16'h00, 1'b1);
        tick();
        #2 nreset = 1'b0;
        #1;
        chk("rst_async_w8", {busy8, done8, r8, z8, n8, h8, c8}, 32'h0);
        tick();
        tick();
        nreset = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done8) seen++;
        end
        chk("no_done_after_rst", seen, 0);

        st_op[0]    = 3'd7;
        st_start[0] = 1'b1;
        st_op[1]    = 3'd5;
        st_start[1] = 1'b1;
        tick();
        chk("rsv_busy", {busy8, busy16}, 2'b00);
        st_start[0] = 1'b0;
        st_start[1] = 1'b0;
        tick();
        chk("rsv_done", {done8, done16}, 2'b00);

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                st_start[i] = 1'($urandom_range(0, 1));
                st_op[i]    = 3'($urandom_range(0, 7));
                st_a[i]     = pick();
                st_b[i]     = pick();
                st_cin[i]   = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_addsub.md
ALU_SERIAL_ADDSUB -- requirements
Module: alu_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be a multiple of 4 in 4..32 (elaboration error otherwise).
REQ-002 Derived NIBBLES = WIDTH/4, number of nibble steps.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only when state is IDLE or DONE.
REQ-006 op  input  3  operation: ADD=0, ADC=1, SUB=2, SBC=3, CP=4; 5..7 reserved.
REQ-007 a  input  WIDTH  first operand, sampled at acceptance.
REQ-008 b  input  WIDTH  second operand, sampled at acceptance.
REQ-009 cin  input  1  carry/borrow-in for ADC/SBC, sampled at acceptance.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  single-cycle pulse; result and flags valid.
REQ-012 result  output  WIDTH  a+b+ci or a-b-ci; a for CP.
REQ-013 flag_z, flag_n, flag_h, flag_c  output  1 each  zero, subtract, half-carry/borrow, carry/borrow.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after last nibble; DONE->RUN on accepted start, else DONE->IDLE.
REQ-015 Acceptance latches a, b, op, cin; nibble index cleared to 0; internal carry = ci (ADD/SUB/CP: ci=0; ADC/SBC: ci=cin).
REQ-016 Subtract ops (SUB/SBC/CP) SHALL add ~b with carry-in ~ci; borrow = inverted carry-out.
REQ-017 RUN SHALL process exactly one 4-bit nibble per cycle, LSB nibble first, carry chained between cycles through one register.
REQ-018 Latency: start accepted at edge t -> done high in cycle t+NIBBLES+1 (WIDTH=8: 3 cycles; WIDTH=16: 5).
REQ-019 flag_h = carry-out (borrow for subtract ops) of nibble 0 only, i.e. out of bit 3, for every WIDTH.
REQ-020 flag_c = carry-out (borrow) of the last nibble.
REQ-021 flag_z = 1 iff the full WIDTH-bit sum/difference is zero (for CP: a==b).
REQ-022 flag_n = 1 for SUB/SBC/CP, 0 for ADD/ADC.
REQ-023 result and all flags SHALL update only on the edge entering DONE and hold until the next entry to DONE.
REQ-024 start while busy SHALL be ignored; operands and in-flight operation unaffected.
REQ-025 start with reserved op SHALL be ignored (no state change, no done).
REQ-026 start in DONE SHALL be accepted back-to-back: done pulse still occurs that cycle, busy rises next cycle.
REQ-027 done SHALL never be high for two consecutive cycles.

Reset
REQ-028 nreset low SHALL asynchronously force IDLE, busy=0, done=0, result=0, all flags 0, nibble index 0, carry 0.
REQ-029 Reset during RUN SHALL abort the operation; no done pulse for it after release.
REQ-030 First start accepted on the first rising edge after nreset deasserts.

Structure
REQ-031 Shared package alu_serial_pkg SHALL hold the op enum (ADD..CP), FSM state enum, and NIBBLE_BITS=4.
REQ-032 One combinational sub-module alu_nibble_add (4-bit a, 4-bit b, ci -> 4-bit s, co) SHALL be instantiated once and reused each cycle.
REQ-033 Nibble index counter SHALL be $clog2(NIBBLES) bits (min 1) and wrap to 0 on acceptance.

Verification
REQ-034 WIDTH=8, ADD a=0x0F b=0x01 -> done at t+3, result=0x10, Z=0 N=0 H=1 C=0.
REQ-035 WIDTH=8, ADC a=0xFF b=0x00 cin=1 -> result=0x00, Z=1 N=0 H=1 C=1.
REQ-036 WIDTH=8, SUB a=0x10 b=0x01 -> result=0x0F, Z=0 N=1 H=1 C=0; then CP a=0x42 b=0x42 back-to-back in DONE cycle -> result=0x42, Z=1 N=1 H=0 C=0.
REQ-037 WIDTH=16, ADD a=0xFFFF b=0x0001 -> done at t+5, result=0x0000, Z=1 H=1 C=1; start pulsed at t+2 ignored.
REQ-038 WIDTH=8, SBC a=0x00 b=0x00 cin=1, nreset low at t+2 -> all outputs 0 immediately, no done afterward; reserved op=7 start -> no busy, no done.
REQ-039 Formal bench (WIDTH 4, 8, 16): $anyconst a/b/cin/op, assert result and all four flags at done match reference arithmetic on WIDTH+1 and 5-bit nibble-0 sums.
